// File: rtl/sm_imem_loader.sv
// rtl/sm_imem_loader.sv - instruction memory loader: streams a counted program into IMEM while holding the CPU
// RUN passes CPU fetches through; a load header then little-endian words are written one per WRITE cycle.
module sm_imem_loader #(
  parameter int SIZE = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_req,
  input  logic        load_abort,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [31:0] cpu_pc,
  output logic [31:0] cpu_instr,
  output logic        cpu_rst_n,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic        busy,
  output logic        err
);

  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [16:0] SIZE_W = 17'(SIZE);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {RUN, HDR0, HDR1, DATA, WRITE} state_t;

  state_t         state_q, state_d;
  logic [15:0]    n_q, n_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [1:0]     byte_cnt_q, byte_cnt_d;
  logic [31:0]    word_q, word_d;
  logic           err_q, err_d;
  logic           cpu_rst_n_q;
  logic           accept;
  logic [15:0]    n_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      n_q         <= '0;
      addr_q      <= '0;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      addr_q      <= addr_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      err_q       <= err_d;
      // state_d is never RUN when load_req starts a load, so this also covers that exit
      cpu_rst_n_q <= (state_d == RUN);
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    addr_d     = addr_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    err_d      = err_q;
    mem_we     = 1'b0;
    rx_ready   = (state_q == HDR0) || (state_q == HDR1) || (state_q == DATA);
    accept     = rx_valid && rx_ready && !load_abort;
    n_full     = {rx_data, n_q[7:0]};

    if (state_q != RUN && load_abort) begin
      state_d = RUN;
      err_d   = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (load_req) begin
            state_d = HDR0;
            err_d   = 1'b0;
          end
        end
        HDR0: begin
          if (accept) begin
            n_d[7:0] = rx_data;
            state_d  = HDR1;
          end
        end
        HDR1: begin
          if (accept) begin
            n_d        = n_full;
            addr_d     = '0;
            byte_cnt_d = '0;
            if (n_full == 16'd0) begin
              state_d = RUN;
            end else if ({1'b0, n_full} > SIZE_W) begin
              state_d = RUN;
              err_d   = 1'b1;
            end else begin
              state_d = DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            word_d[8*byte_cnt_q +: 8] = rx_data;
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) state_d = WRITE;
          end
        end
        WRITE: begin
          mem_we = 1'b1;
          if (16'(addr_q) == n_q - 16'd1) begin
            state_d = RUN;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = DATA;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign busy      = (state_q != RUN);
  assign err       = err_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign mem_wd    = word_q;
  assign mem_addr  = busy ? 32'(addr_q) : cpu_pc;
  assign cpu_instr = busy ? NOP : mem_rd;

endmodule

// File: doc/sm_imem_loader.md
SM_IMEM_LOADER -- requirements
Module: sm_imem_loader

Interface
REQ-001 SHALL have parameter SIZE, default 64, instruction memory depth in 32-bit words.
REQ-002 SHALL have port clk, input, 1, single system clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port load_req, input, 1, single-cycle request to start a program load.
REQ-005 SHALL have port load_abort, input, 1, cancel an in-progress load.
REQ-006 SHALL have port rx_data, input, 8, host byte stream data.
REQ-007 SHALL have port rx_valid, input, 1, host byte valid.
REQ-008 SHALL have port rx_ready, output, 1, loader accepts a byte this cycle.
REQ-009 SHALL have port cpu_pc, input, 32, CPU fetch word index.
REQ-010 SHALL have port cpu_instr, output, 32, instruction returned to the CPU.
REQ-011 SHALL have port cpu_rst_n, output, 1, active-low hold for the CPU core.
REQ-012 SHALL have port mem_addr, output, 32, instruction memory word index.
REQ-013 SHALL have port mem_we, output, 1, instruction memory write strobe.
REQ-014 SHALL have port mem_wd, output, 32, instruction memory write data.
REQ-015 SHALL have port mem_rd, input, 32, instruction memory read data (combinational, zero latency).
REQ-016 SHALL have ports busy and err, outputs, 1 each: load in progress; sticky load error.

Function
REQ-017 SHALL implement states RUN, HDR0, HDR1, DATA, WRITE.
REQ-018 A byte SHALL be accepted only on a cycle with rx_valid && rx_ready; rx_ready SHALL be 1 exactly in HDR0, HDR1, DATA.
REQ-019 RUN: mem_addr = cpu_pc, cpu_instr = mem_rd, mem_we = 0; load_req -> HDR0, clear err.
REQ-020 HDR0/HDR1 SHALL capture a 16-bit word count N, little-endian (HDR0 low byte), then HDR1 -> DATA, clearing word address and byte counter.
REQ-021 On HDR1 acceptance: N == 0 -> RUN with no writes; N > SIZE -> RUN, err = 1, no writes.
REQ-022 DATA SHALL assemble 4 accepted bytes little-endian (first byte -> bits 7:0); after the 4th byte -> WRITE.
REQ-023 WRITE SHALL last exactly one cycle: mem_we = 1, mem_addr = current word address, mem_wd = assembled word; next state is RUN if address == N-1, else DATA with address +1.
REQ-024 Outside RUN, cpu_instr SHALL be 32'h00000013 (NOP) and mem_addr SHALL be the load word address.
REQ-025 load_req outside RUN SHALL be ignored.
REQ-026 load_abort in any state other than RUN SHALL force RUN next cycle, set err = 1, and suppress any mem_we that cycle; load_abort has priority over byte acceptance.
REQ-027 load_req and load_abort both high in RUN: load_abort ignored, load starts.
REQ-028 busy SHALL equal (state != RUN).
REQ-029 cpu_rst_n SHALL be a register loaded each cycle with (next state == RUN) and not load_req-triggered exit; effectively 0 from the cycle after load_req is taken until the cycle after return to RUN.
REQ-030 Word address SHALL be ceil(log2(SIZE)) bits, zero-extended onto mem_addr; no wrap occurs because N <= SIZE.

Reset
REQ-031 With rst_n = 0 at a clock edge: state = RUN, cpu_rst_n = 0, err = 0, byte counter = 0, word address = 0, N = 0.
REQ-032 rst_n = 0 mid-load SHALL abandon the load with no further writes and without setting err; cpu_rst_n becomes 1 on the first edge with rst_n = 1.
REQ-033 Outputs during and after reset are as in RUN: rx_ready = 0, mem_we = 0, busy = 0.

Verification
REQ-034 Reset released, cpu_pc = 5, mem_rd = 32'h00500093 -> cpu_instr = 32'h00500093, mem_addr = 5, cpu_rst_n = 1 one cycle after reset release.
REQ-035 load_req, bytes 02 00 13 00 00 00 B7 12 00 00 -> writes 32'h00000013 @0 then 32'h000012B7 @1, each mem_we one cycle, then RUN, cpu_rst_n = 1 one cycle later, err = 0.
REQ-036 Same load with rx_valid toggled 1/0 every cycle -> identical writes; no byte lost or duplicated.
REQ-037 Header 41 00 (N = 65, SIZE = 64) -> no mem_we, err = 1, back in RUN after HDR1.
REQ-038 load_abort after 2 data bytes -> RUN next cycle, err = 1, no write; rst_n = 0 mid-load -> RUN, err = 0.
